// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - MAR/MBR holder and multi-cycle SRAM / I/O access sequencer
// Strobes are registered from the next-state decode so they change only on clock edges.
module mem_interface #(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 3,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        zero_page,
  input  logic        mem_part,
  input  logic        mem_out,
  input  logic        mem_in,
  input  logic        reg_mbr_load,
  input  logic        reg_mbr_word_dir,
  input  logic        reg_mar_load,
  input  logic [15:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  output logic        ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        ram_ce_n,
  output logic        io_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_CNT  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic             r_op;
  logic             r_part;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_mar;
  logic [7:0]       r_mbr;
  logic             r_bus_err;
  logic             r_ram_ce_n;
  logic             r_io_ce_n;
  logic             r_oe_n;
  logic             r_we_n;

  logic [1:0] w_next_state;
  logic       w_next_op;
  logic       w_next_part;
  logic       w_capture;
  logic       w_req_err;
  logic       w_next_active;

  // r_op: 0 = read into MBR, 1 = write MBR out
  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op;
    w_next_part  = r_part;
    w_capture    = 1'b0;
    w_req_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_out ^ mem_in) begin
          w_next_state = S_SETUP;
          w_next_op    = mem_in;
          w_next_part  = mem_part;
        end else if (mem_out & mem_in) begin
          w_req_err = 1'b1;
        end
      end
      S_SETUP:  w_next_state = S_STROBE;
      S_STROBE: begin
        if (r_cnt == CNT_ONE) begin
          w_next_state = S_HOLD;
          w_capture    = ~r_op;
        end
      end
      S_HOLD:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign w_next_active = (w_next_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_part     <= 1'b0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
      r_ram_ce_n <= 1'b1;
      r_io_ce_n  <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_op      <= w_next_op;
      r_part    <= w_next_part;
      r_bus_err <= w_req_err;
      if (r_state == S_SETUP) begin
        r_cnt <= r_part ? IO_CNT : RAM_CNT;
      end else if (r_state == S_STROBE) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      r_ram_ce_n <= ~(w_next_active & ~w_next_part);
      r_io_ce_n  <= ~(w_next_active & w_next_part);
      r_oe_n     <= ~((w_next_state == S_STROBE) & ~w_next_op);
      r_we_n     <= ~((w_next_state == S_STROBE) & w_next_op);
    end
  end

  // Read capture takes priority over a same-edge CPU load of the MBR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mar <= '0;
      r_mbr <= '0;
    end else begin
      if (reg_mar_load) begin
        r_mar <= zero_page ? {8'h00, addr_bus[7:0]} : addr_bus;
      end
      if (w_capture) begin
        r_mbr <= mem_rdata;
      end else if (reg_mbr_load) begin
        r_mbr <= data_bus;
      end
    end
  end

  assign data_bus  = (reg_mbr_word_dir && !reg_mbr_load) ? r_mbr : 8'hzz;
  assign ready     = (r_state == S_IDLE);
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mbr;
  assign ram_ce_n  = r_ram_ce_n;
  assign io_ce_n   = r_io_ce_n;
  assign mem_oe_n  = r_oe_n;
  assign mem_we_n  = r_we_n;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_interface.sv
// tb/tb_mem_interface.sv - directed plus randomized self-checking bench for mem_interface
module tb_mem_interface;

  localparam int RAM_W = 1;
  localparam int IO_W  = 3;

  logic        clk;
  logic        rst;
  logic        zero_page;
  logic        mem_part;
  logic        mem_out;
  logic        mem_in;
  logic        reg_mbr_load;
  logic        reg_mbr_word_dir;
  logic        reg_mar_load;
  logic [15:0] addr_bus;
  wire  [7:0]  data_bus;
  logic        ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        ram_ce_n;
  logic        io_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        bus_err;

  logic [7:0] tb_drv;
  logic       tb_drv_en;
  int         checks;
  int         passed;

  assign data_bus = tb_drv_en ? tb_drv : 8'hzz;

  mem_interface #(.RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .zero_page(zero_page), .mem_part(mem_part),
    .mem_out(mem_out), .mem_in(mem_in), .reg_mbr_load(reg_mbr_load),
    .reg_mbr_word_dir(reg_mbr_word_dir), .reg_mar_load(reg_mar_load),
    .addr_bus(addr_bus), .data_bus(data_bus), .ready(ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ram_ce_n(ram_ce_n), .io_ce_n(io_ce_n), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs(input logic zp, input logic [15:0] addr, input logic [7:0] wdata);
    zero_page = zp; addr_bus = addr; reg_mar_load = 1'b1;
    tb_drv = wdata; tb_drv_en = 1'b1; reg_mbr_load = 1'b1;
    tick();
    reg_mar_load = 1'b0; reg_mbr_load = 1'b0; tb_drv_en = 1'b0;
    check("mar_load", mem_addr, zp ? {8'h00, addr[7:0]} : addr);
    check("mbr_load", {8'h00, mem_wdata}, {8'h00, wdata});
  endtask

  // Counts strobe activity from the request edge until ready returns and
  // compares it with the wait-state rule: CE for N+2 cycles, OE/WE for N.
  task automatic run_access(input logic wr, input logic part, input logic zp,
                            input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [7:0] rdata);
    int n_wait, rdy_lo, ce_lo, ce_other, stb_lo, stb_other, err_cnt;
    logic [15:0] exp_addr;
    logic [7:0]  exp_mbr;
    n_wait   = part ? IO_W : RAM_W;
    exp_addr = zp ? {8'h00, addr[7:0]} : addr;
    exp_mbr  = wr ? wdata : rdata;
    rdy_lo = 0; ce_lo = 0; ce_other = 0; stb_lo = 0; stb_other = 0; err_cnt = 0;
    load_regs(zp, addr, wdata);
    mem_rdata = rdata; mem_part = part;
    mem_out = ~wr; mem_in = wr;
    tick();
    mem_out = 1'b0; mem_in = 1'b0; mem_part = ~part;
    for (int i = 0; i < 40 && !ready; i++) begin
      rdy_lo++;
      if (!(part ? io_ce_n : ram_ce_n)) ce_lo++;
      if (!(part ? ram_ce_n : io_ce_n)) ce_other++;
      if (!(wr ? mem_we_n : mem_oe_n)) stb_lo++;
      if (!(wr ? mem_oe_n : mem_we_n)) stb_other++;
      if (bus_err) err_cnt++;
      if (wr && mem_wdata !== wdata) err_cnt++;
      if (mem_addr !== exp_addr) err_cnt++;
      tick();
    end
    check("ready_low_cycles", 16'(rdy_lo), 16'(n_wait + 2));
    check("ce_low_cycles", 16'(ce_lo), 16'(n_wait + 2));
    check("other_ce_low", 16'(ce_other), 16'd0);
    check("strobe_low_cycles", 16'(stb_lo), 16'(n_wait));
    check("wrong_strobe_low", 16'(stb_other), 16'd0);
    check("hold_errors", 16'(err_cnt), 16'd0);
    reg_mbr_word_dir = 1'b1;
    #1;
    check("data_bus_mbr", {8'h00, data_bus}, {8'h00, exp_mbr});
    reg_mbr_word_dir = 1'b0;
  endtask

  initial begin
    int rdy_lo, extra;
    checks = 0; passed = 0;
    rst = 1'b0; zero_page = 1'b0; mem_part = 1'b0; mem_out = 1'b0; mem_in = 1'b0;
    reg_mbr_load = 1'b0; reg_mbr_word_dir = 1'b0; reg_mar_load = 1'b0;
    addr_bus = 16'h0; mem_rdata = 8'h0; tb_drv = 8'h0; tb_drv_en = 1'b0;
    #12;
    check("rst_ready", {15'd0, ready}, 16'd1);
    check("rst_strobes", {12'd0, ram_ce_n, io_ce_n, mem_oe_n, mem_we_n}, 16'hF);
    check("rst_bus_err", {15'd0, bus_err}, 16'd0);
    check("rst_mar", mem_addr, 16'h0);
    checks++;
    assert (data_bus === 8'hzz) passed++;
    else $error("FAIL rst_data_bus observed=%h expected=zz", data_bus);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // RAM read and zero-page I/O write
    run_access(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5);
    run_access(1'b1, 1'b1, 1'b1, 16'hBEEF, 8'h3C, 8'h00);

    // Illegal request: both directions at once
    mem_out = 1'b1; mem_in = 1'b1;
    tick();
    mem_out = 1'b0; mem_in = 1'b0;
    check("illegal_bus_err", {15'd0, bus_err}, 16'd1);
    check("illegal_ready", {15'd0, ready}, 16'd1);
    check("illegal_strobes", {12'd0, ram_ce_n, io_ce_n, mem_oe_n, mem_we_n}, 16'hF);
    tick();
    check("illegal_err_clear", {15'd0, bus_err}, 16'd0);

    // Busy request ignored: I/O read with an extra mem_out pulse mid-access
    mem_part = 1'b1; mem_out = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_out = 1'b0;
    rdy_lo = 0; extra = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      rdy_lo++;
      mem_out = (i == 2);
      tick();
    end
    mem_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!ready || !io_ce_n) extra++;
      tick();
    end
    check("busy_ready_low", 16'(rdy_lo), 16'(IO_W + 2));
    check("busy_no_second", 16'(extra), 16'd0);

    // Collision: CPU load of MBR on the read-capture edge loses
    load_regs(1'b0, 16'h0040, 8'h00);
    mem_part = 1'b0; mem_out = 1'b1; mem_rdata = 8'h22;
    tick();
    mem_out = 1'b0;
    tick();
    check("collision_in_strobe", {15'd0, mem_oe_n}, 16'd0);
    reg_mbr_load = 1'b1; tb_drv = 8'h11; tb_drv_en = 1'b1;
    tick();
    reg_mbr_load = 1'b0; tb_drv_en = 1'b0;
    for (int i = 0; i < 10 && !ready; i++) tick();
    check("collision_mbr", {8'h00, mem_wdata}, 16'h0022);

    // Asynchronous reset during an I/O write strobe
    load_regs(1'b0, 16'h8001, 8'h77);
    mem_part = 1'b1; mem_in = 1'b1;
    tick();
    mem_in = 1'b0;
    tick();
    check("pre_rst_we", {15'd0, mem_we_n}, 16'd0);
    rst = 1'b0;
    #2;
    check("arst_strobes", {14'd0, mem_we_n, io_ce_n}, 16'h3);
    check("arst_ready", {15'd0, ready}, 16'd1);
    check("arst_mar", mem_addr, 16'h0);
    check("arst_mbr", {8'h00, mem_wdata}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_access(1'b0, 1'b0, 1'b0, 16'h0F0F, 8'h00, 8'hC3);

    // Randomized accesses against the wait-state model
    for (int k = 0; k < 10; k++) begin
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
